// File: rtl/hycube_config_loader.sv
// hycube_config_loader: word-serial bitstream parser that assembles frame rows
// and drives FrameData/FrameStrobe of a parametrised hycube-style CGRA fabric.
module hycube_config_loader #(
  parameter int NumRows         = 3,
  parameter int NumColumns      = 3,
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramePerCol  = 32
) (
  input  logic                                 UserCLK,
  input  logic                                 resetn,
  input  logic [FrameBitsPerRow-1:0]           s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [NumColumns*MaxFramePerCol-1:0] FrameStrobe,
  output logic                                 synced,
  output logic                                 config_done,
  output logic                                 error,
  output logic [15:0]                          frames_written
);

  localparam int DataW   = NumRows * FrameBitsPerRow;
  localparam int StrobeW = NumColumns * MaxFramePerCol;
  localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int IdxW    = (StrobeW > 1) ? $clog2(StrobeW) : 1;

  localparam logic [31:0]     Sync    = 32'hFAB0_FAB1;
  localparam logic [31:0]     Desync  = 32'hFAB0_DE5C;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_HEADER,
    S_DATA,
    S_STROBE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                       r_ready;
  logic [RowW-1:0]            r_row;
  logic [7:0]                 r_col;
  logic [7:0]                 r_frame;
  logic [FrameBitsPerRow-1:0] r_shadow [NumRows];
  logic [DataW-1:0]           r_frame_data;
  logic [StrobeW-1:0]         r_strobe;
  logic                       r_synced;
  logic                       r_done;
  logic                       r_error;
  logic [15:0]                r_count;

  logic               w_fire;
  logic               w_is_sync;
  logic               w_is_desync;
  logic               w_hdr_ok;
  logic               w_clr;
  logic               w_desync;
  logic               w_err;
  logic               w_latch;
  logic               w_wr;
  logic               w_last;
  logic [IdxW-1:0]    w_idx;
  logic [StrobeW-1:0] w_onehot;
  logic [DataW-1:0]   w_frame;

  assign w_fire      = s_valid && r_ready;
  assign w_is_sync   = (s_data[31:0] == Sync);
  assign w_is_desync = (s_data[31:0] == Desync);
  assign w_hdr_ok    = (s_data[31:24] == 8'hA0)
                    && ({1'b0, s_data[15:8]} < 9'(NumColumns))
                    && ({1'b0, s_data[7:0]} < 9'(MaxFramePerCol));

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_desync = 1'b0;
    w_err    = 1'b0;
    w_latch  = 1'b0;
    w_wr     = 1'b0;
    w_last   = 1'b0;
    unique case (r_state)
      S_HUNT: begin
        if (w_fire && w_is_sync) begin
          w_clr  = 1'b1;
          w_next = S_HEADER;
        end
      end
      S_HEADER: begin
        if (w_fire) begin
          unique case (1'b1)
            w_is_sync: begin
              w_clr = 1'b1;
            end
            w_is_desync: begin
              w_desync = 1'b1;
              w_next   = S_HUNT;
            end
            w_hdr_ok: begin
              w_latch = 1'b1;
              w_next  = S_DATA;
            end
            default: begin
              w_err  = 1'b1;
              w_next = S_HUNT;
            end
          endcase
        end
      end
      S_DATA: begin
        if (w_fire) begin
          w_wr = 1'b1;
          if (r_row == LastRow) begin
            w_last = 1'b1;
            w_next = S_STROBE;
          end
        end
      end
      S_STROBE: begin
        w_next = S_HEADER;
      end
      default: begin
        w_next = S_HUNT;
      end
    endcase
  end

  // The last row bypasses the shadow so the frame is complete on its own edge.
  always_comb begin
    w_frame = '0;
    for (int r = 0; r < NumRows; r++) begin
      w_frame[r*FrameBitsPerRow +: FrameBitsPerRow] =
        (r_row == RowW'(r)) ? s_data : r_shadow[r];
    end
  end

  assign w_idx    = IdxW'(r_col) * IdxW'(MaxFramePerCol) + IdxW'(r_frame);
  assign w_onehot = StrobeW'(1) << w_idx;

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_frame <= '0;
    end else begin
      r_ready <= (w_next != S_STROBE);
      if (w_latch) begin
        r_row   <= '0;
        r_col   <= s_data[15:8];
        r_frame <= s_data[7:0];
      end else if (w_wr) begin
        r_row <= w_last ? '0 : r_row + RowW'(1);
      end
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NumRows; r++) begin
        r_shadow[r] <= '0;
      end
    end else if (w_wr) begin
      for (int r = 0; r < NumRows; r++) begin
        if (r_row == RowW'(r)) begin
          r_shadow[r] <= s_data;
        end
      end
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_frame_data <= '0;
      r_strobe     <= '0;
    end else begin
      r_strobe <= w_last ? w_onehot : '0;
      if (w_last) begin
        r_frame_data <= w_frame;
      end
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_synced <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_clr) begin
        r_synced <= 1'b1;
        r_done   <= 1'b0;
        r_error  <= 1'b0;
        r_count  <= '0;
      end else if (w_desync) begin
        r_synced <= 1'b0;
        r_done   <= 1'b1;
      end else if (w_err) begin
        r_synced <= 1'b0;
        r_error  <= 1'b1;
      end else if (w_last && r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign s_ready        = r_ready;
  assign FrameData      = r_frame_data;
  assign FrameStrobe    = r_strobe;
  assign synced         = r_synced;
  assign config_done    = r_done;
  assign error          = r_error;
  assign frames_written = r_count;

endmodule

// File: tb/tb_hycube_config_loader.sv
// Scoreboard bench for hycube_config_loader: randomized bitstreams checked
// against a word-level protocol model; second instance covers a 1x8 fabric.
module tb_hycube_config_loader;

  localparam int NR = 3;
  localparam int NC = 3;
  localparam int FB = 32;
  localparam int MF = 32;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_DE5C;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [FB-1:0]    s_data  = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [NR*FB-1:0] fdata;
  logic [NC*MF-1:0] fstrobe;
  logic             synced, cdone, err;
  logic [15:0]      fw;

  logic [63:0]  s_data2  = '0;
  logic         s_valid2 = 1'b0;
  logic         s_ready2;
  logic [63:0]  fdata2;
  logic [159:0] fstrobe2;
  logic         synced2, cdone2, err2;
  logic [15:0]  fw2;

  hycube_config_loader #(
    .NumRows(NR), .NumColumns(NC),
    .FrameBitsPerRow(FB), .MaxFramePerCol(MF)
  ) dut (
    .UserCLK(clk), .resetn(rstn),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FrameData(fdata), .FrameStrobe(fstrobe),
    .synced(synced), .config_done(cdone), .error(err),
    .frames_written(fw)
  );

  hycube_config_loader #(
    .NumRows(1), .NumColumns(8),
    .FrameBitsPerRow(64), .MaxFramePerCol(20)
  ) dut2 (
    .UserCLK(clk), .resetn(rstn),
    .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .FrameData(fdata2), .FrameStrobe(fstrobe2),
    .synced(synced2), .config_done(cdone2), .error(err2),
    .frames_written(fw2)
  );

  typedef struct {
    logic [NR*FB-1:0] fd;
    logic [NC*MF-1:0] sb;
  } exp_t;

  exp_t exp_q[$];
  int   strobe_times[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [NR*FB-1:0] cur_fd = '0;

  logic [31:0] m_rows[$];
  bit m_collect, m_synced, m_err, m_done;
  int m_col, m_frame, m_cnt;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_collect = 0;
    m_synced  = 0;
    m_err     = 0;
    m_done    = 0;
    m_cnt     = 0;
    m_rows.delete();
    exp_q.delete();
  endfunction

  // Protocol reference: one call per word the loader accepts.
  function automatic void model_word(input logic [31:0] w);
    exp_t e;
    if (m_collect) begin
      m_rows.push_back(w);
      if (m_rows.size() == NR) begin
        e.fd = '0;
        e.sb = '0;
        for (int i = 0; i < NR; i++) e.fd[i*FB +: FB] = m_rows[i];
        e.sb[m_col*MF + m_frame] = 1'b1;
        exp_q.push_back(e);
        if (m_cnt < 65535) m_cnt++;
        m_collect = 0;
        m_rows.delete();
      end
    end else if (!m_synced) begin
      if (w == SYNC) begin
        m_synced = 1;
        m_err    = 0;
        m_done   = 0;
        m_cnt    = 0;
      end
    end else if (w == SYNC) begin
      m_cnt = 0;
    end else if (w == DESYNC) begin
      m_synced = 0;
      m_done   = 1;
    end else if (w[31:24] == 8'hA0 && int'(w[15:8]) < NC
                 && int'(w[7:0]) < MF) begin
      m_col     = int'(w[15:8]);
      m_frame   = int'(w[7:0]);
      m_collect = 1;
    end else begin
      m_err    = 1;
      m_synced = 0;
    end
  endfunction

  task automatic send(input logic [31:0] w, input bit stall);
    int n = 0;
    bit done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (stall && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_data  = w;
        s_valid = 1'b1;
        done    = s_ready;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: word %0h not accepted", w);
      return;
    end
    @(posedge clk);
    #1;
    model_word(w);
    chk("synced", synced, m_synced);
    chk("error", err, m_err);
    chk("config_done", cdone, m_done);
    chk("frames_written", fw, m_cnt[15:0]);
  endtask

  task automatic send2(input logic [63:0] w);
    int n = 0;
    bit done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      s_data2  = w;
      s_valid2 = 1'b1;
      done     = s_ready2;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL handshake2_timeout: word %0h not accepted", w);
      return;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      cur_fd = '0;
    end else begin
      cyc++;
      if (fstrobe != '0) begin
        strobe_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got %0h required none", fstrobe);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_vec", fstrobe, e.sb);
          chk("strobe_fd", fdata, e.fd);
          chk("strobe_ready", s_ready, 1'b0);
          cur_fd = e.fd;
        end
      end else begin
        chk("fd_hold", fdata, cur_fd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int k;
    int fw_before;
    model_reset();

    #12;
    chk("rst_fd", fdata, 0);
    chk("rst_strobe", fstrobe, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_status", {synced, cdone, err}, 0);
    chk("rst_fw", fw, 0);
    chk("rst_ready2", s_ready2, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", s_ready, 1);

    // Reset in the middle of a frame
    send(SYNC, 0);
    send(32'hA000_0105, 0);
    send(32'h1111_1111, 0);
    #2;
    s_valid = 1'b0;
    rstn    = 1'b0;
    #1;
    chk("mid_rst_fd", fdata, 0);
    chk("mid_rst_strobe", fstrobe, 0);
    chk("mid_rst_status", {s_ready, synced, cdone, err}, 0);
    chk("mid_rst_fw", fw, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", s_ready, 1);
    idle(4);

    // Basic write
    send(SYNC, 0);
    send(32'hA000_0105, 0);
    send(32'h1111_1111, 0);
    send(32'h2222_2222, 0);
    send(32'h3333_3333, 0);
    chk("basic_fd", fdata, 96'h3333_3333_2222_2222_1111_1111);
    chk("basic_strobe", fstrobe, 96'd1 << 37);
    chk("basic_ready", s_ready, 0);
    chk("basic_fw", fw, 1);
    @(posedge clk);
    #1;
    chk("basic_strobe_off", fstrobe, 0);
    idle(3);

    // Back-to-back frames with s_valid held high
    strobe_times.delete();
    send(32'hA000_021F, 0);
    for (int i = 0; i < NR; i++) send($urandom, 0);
    send(32'hA000_0000, 0);
    for (int i = 0; i < NR; i++) send($urandom, 0);
    idle(4);
    chk("b2b_count", strobe_times.size(), 2);
    if (strobe_times.size() == 2)
      chk("b2b_gap", strobe_times[1] - strobe_times[0], NR + 2);

    // Protocol errors
    send(32'hA000_0300, 0);
    chk("perr_flags", {err, synced}, 2'b10);
    send(32'h1234_5678, 0);
    chk("perr_hunt", {err, synced}, 2'b10);
    send(SYNC, 0);
    chk("perr_clear", {err, synced}, 2'b01);
    idle(2);

    // Keywords as row data, with stalls
    send(32'hA000_0203, 1);
    send(SYNC, 1);
    send(DESYNC, 1);
    send(32'h0, 1);
    idle(2);
    fw_before = int'(fw);
    send(DESYNC, 1);
    chk("desync_flags", {cdone, synced}, 2'b10);
    chk("desync_fw", fw, fw_before[15:0]);
    idle(2);

    // Randomized protocol traffic
    for (int i = 0; i < 300; i++) begin
      if (m_collect) begin
        w = $urandom;
      end else if (!m_synced) begin
        w = ($urandom_range(0, 1) == 1) ? SYNC : $urandom;
      end else begin
        k = $urandom_range(0, 99);
        if (k < 80)
          w = {8'hA0, 8'($urandom), 8'($urandom_range(0, 3)),
               8'($urandom_range(0, 35))};
        else if (k < 88) w = DESYNC;
        else if (k < 94) w = SYNC;
        else w = $urandom;
      end
      send(w, bit'($urandom_range(0, 1)));
    end
    idle(10);
    chk("scoreboard_empty", exp_q.size(), 0);

    // 1x8 fabric, 64-bit rows, 20 frames per column
    send2({32'h0, SYNC});
    send2({32'h0, 32'hA000_0713});
    send2(64'hDEAD_BEEF_0123_4567);
    chk("p_strobe", fstrobe2, 160'd1 << 159);
    chk("p_fd", fdata2, 64'hDEAD_BEEF_0123_4567);
    chk("p_fw", fw2, 1);
    chk("p_ready", s_ready2, 0);
    @(posedge clk);
    #1;
    chk("p_strobe_off", fstrobe2, 0);
    send2({32'h0, 32'hA000_0014});
    chk("p_err", {err2, synced2}, 2'b10);
    @(negedge clk);
    s_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("p_fd_hold", fdata2, 64'hDEAD_BEEF_0123_4567);
    chk("p_no_strobe", fstrobe2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
